// File: rtl/apb3_requester.sv
// APB3 requester: valid/ready command in, SETUP/ACCESS transfer out, response held until RSP_READY.
// Latency: a handshake at edge t gives RSP_VALID in cycle t+3 plus wait states. The request side stalls until the response is consumed.
module apb3_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    unique case (state_q)
      IDLE: begin
        if (REQ_VALID && req_ready_q) begin
          paddr_d  = REQ_ADDR;
          pwrite_d = REQ_WRITE;
          pwdata_d = REQ_WDATA;
          cnt_d    = '0;
          // Misaligned commands are answered locally without touching the bus.
          if (|(REQ_ADDR & ALIGN_MASK)) begin
            state_d       = RESP;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_d       = RESP;
          rsp_rdata_d   = (pwrite_q || PSLVERR) ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          if (TO_EN && (cnt_inc == TO_VAL)) begin
            state_d       = RESP;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      RESP: if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake/bus strobes are decoded from the next state so they come straight from flops.
    req_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
    end
  end

  assign REQ_READY   = req_ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_ERR     = rsp_err_q;
  assign RSP_TIMEOUT = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb3_requester.sv
// Directed bench for apb3_requester: table of single transfers with a scripted completer,
// plus hand-written reset, throughput and mid-transfer reset sequences.
module tb_apb3_requester;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WRITE = 1'b0;
  logic [31:0] REQ_ADDR = '0;
  logic [31:0] REQ_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int checks = 0;
  int failures = 0;

  apb3_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;     // wait states before PREADY; 255 = never ready
    logic        serr_wait; // PSLVERR driven while PREADY=0
    logic        serr_fin;  // PSLVERR driven with PREADY=1
    int          hold;      // cycles RSP_READY held low once RSP_VALID is seen
    int          e_lat;     // cycles from handshake edge to RSP_VALID
    int          e_psel;
    int          e_pen;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string nm, input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, what, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n, lat, npsel, npen, nacc, bad, busy_rdy;
    n = 0;
    while (!REQ_READY && n < 20) begin
      tick();
      n++;
    end
    chk(v.name, "req_ready_idle", REQ_READY, 1);
    REQ_VALID = 1'b1;
    REQ_WRITE = v.wr;
    REQ_ADDR  = v.addr;
    REQ_WDATA = v.wdata;
    PRDATA    = v.prdata;
    RSP_READY = 1'b0;
    tick();
    REQ_VALID = 1'b0;
    lat = 1; npsel = 0; npen = 0; nacc = 0; bad = 0; busy_rdy = 0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    while (!RSP_VALID && lat < 40) begin
      if (REQ_READY) busy_rdy++;
      if (PSEL) begin
        npsel++;
        if (PADDR !== v.addr || PWDATA !== v.wdata || PWRITE !== v.wr) bad++;
      end
      if (PENABLE) begin
        npen++;
        nacc++;
        PREADY  = (nacc == v.waits + 1);
        PSLVERR = PREADY ? v.serr_fin : v.serr_wait;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      tick();
      lat++;
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    chk(v.name, "latency", lat, v.e_lat);
    chk(v.name, "psel_cycles", npsel, v.e_psel);
    chk(v.name, "penable_cycles", npen, v.e_pen);
    chk(v.name, "apb_fields_stable", bad, 0);
    chk(v.name, "req_ready_busy", busy_rdy, 0);
    chk(v.name, "rsp_rdata", RSP_RDATA, v.e_rdata);
    chk(v.name, "rsp_err", RSP_ERR, v.e_err);
    chk(v.name, "rsp_timeout", RSP_TIMEOUT, v.e_to);
    chk(v.name, "psel_in_resp", PSEL, 0);
    for (int i = 0; i < v.hold; i++) begin
      tick();
      chk(v.name, "hold_rsp_valid", RSP_VALID, 1);
      chk(v.name, "hold_rsp_rdata", RSP_RDATA, v.e_rdata);
      chk(v.name, "hold_rsp_err", RSP_ERR, v.e_err);
      chk(v.name, "hold_req_ready", REQ_READY, 0);
    end
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk(v.name, "rsp_valid_drop", RSP_VALID, 0);
    chk(v.name, "req_ready_back", REQ_READY, 1);
  endtask

  vec_t vecs[9];

  initial begin
    int hs_cnt, rsp_cnt, last, gap_bad;
    vec_t rv;

    //          name        wr    addr   wdata         prdata        wt  sw    sf    hold lat psel pen e_rdata       err   to
    vecs[0] = '{"wr_fast",  1'b1, 32'h8,   32'hDEADBEEF, 32'h55AA55AA, 0,   1'b0, 1'b0, 0, 3,  2,  1,  32'h0,        1'b0, 1'b0};
    vecs[1] = '{"rd_wait3", 1'b0, 32'h8,   32'h0,        32'hDEADBEEF, 3,   1'b0, 1'b0, 0, 6,  5,  4,  32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{"rd_slverr",1'b0, 32'h10,  32'h0,        32'h12345678, 0,   1'b0, 1'b1, 0, 3,  2,  1,  32'h0,        1'b1, 1'b0};
    vecs[3] = '{"rd_errign",1'b0, 32'h14,  32'h0,        32'hCAFEF00D, 2,   1'b1, 1'b0, 0, 5,  4,  3,  32'hCAFEF00D, 1'b0, 1'b0};
    vecs[4] = '{"rd_tmo",   1'b0, 32'h20,  32'h0,        32'h77777777, 255, 1'b0, 1'b0, 0, 18, 17, 16, 32'h0,        1'b1, 1'b1};
    vecs[5] = '{"rd_rdy16", 1'b0, 32'h24,  32'h0,        32'h0A0B0C0D, 15,  1'b0, 1'b0, 0, 18, 17, 16, 32'h0A0B0C0D, 1'b0, 1'b0};
    vecs[6] = '{"wr_mis6",  1'b1, 32'h6,   32'h13572468, 32'h0,        0,   1'b0, 1'b0, 5, 1,  0,  0,  32'h0,        1'b1, 1'b0};
    vecs[7] = '{"rd_mis3",  1'b0, 32'h3,   32'h0,        32'hFFFFFFFF, 0,   1'b0, 1'b0, 1, 1,  0,  0,  32'h0,        1'b1, 1'b0};
    vecs[8] = '{"wr_slverr",1'b1, 32'h100, 32'hA5A5A5A5, 32'hFFFFFFFF, 1,   1'b0, 1'b1, 2, 4,  3,  2,  32'h0,        1'b1, 1'b0};

    // Reset state
    tick();
    tick();
    chk("reset", "req_ready", REQ_READY, 0);
    chk("reset", "rsp_valid", RSP_VALID, 0);
    chk("reset", "psel", PSEL, 0);
    chk("reset", "penable", PENABLE, 0);
    chk("reset", "paddr", PADDR, 0);
    chk("reset", "rsp_err", RSP_ERR, 0);
    RST_N = 1'b0;
    tick();
    chk("reset", "req_ready_after", REQ_READY, 1);

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Back-to-back throughput with RSP_READY tied high
    hs_cnt = 0; rsp_cnt = 0; last = -1; gap_bad = 0;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 32'h50; REQ_WDATA = 32'h0;
    PREADY = 1'b1; RSP_READY = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (REQ_READY) begin
        hs_cnt++;
        if (last >= 0 && c - last != 4) gap_bad++;
        last = c;
      end
      if (RSP_VALID) rsp_cnt++;
      tick();
    end
    REQ_VALID = 1'b0;
    tick();
    PREADY = 1'b0; RSP_READY = 1'b0;
    chk("b2b", "handshakes", hs_cnt, 3);
    chk("b2b", "spacing_errs", gap_bad, 0);
    chk("b2b", "responses", rsp_cnt, 3);
    chk("b2b", "idle_ready", REQ_READY, 1);

    // Reset during ACCESS of a write, with a new request held across the reset
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 32'h40; REQ_WDATA = 32'h11112222;
    tick();
    REQ_VALID = 1'b0;
    chk("rst_mid", "setup_psel", PSEL, 1);
    tick();
    chk("rst_mid", "access_penable", PENABLE, 1);
    chk("rst_mid", "access_paddr", PADDR, 32'h40);
    RST_N = 1'b1;
    PREADY = 1'b1;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 32'h44; REQ_WDATA = 32'h33334444;
    tick();
    chk("rst_mid", "psel", PSEL, 0);
    chk("rst_mid", "penable", PENABLE, 0);
    chk("rst_mid", "rsp_valid", RSP_VALID, 0);
    chk("rst_mid", "req_ready", REQ_READY, 0);
    chk("rst_mid", "paddr", PADDR, 0);
    chk("rst_mid", "pwdata", PWDATA, 0);
    chk("rst_mid", "pwrite", PWRITE, 0);
    RST_N = 1'b0;
    PREADY = 1'b0;
    tick();
    chk("rst_mid", "no_rsp_after", RSP_VALID, 0);
    rv = '{"rst_held", 1'b1, 32'h44, 32'h33334444, 32'h0, 0, 1'b0, 1'b0, 0, 3, 2, 1, 32'h0, 1'b0, 1'b0};
    run_txn(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb3_requester.md
Name: apb3_requester

Overview:
- APB3 requester (master) that converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers.
- Returns each transfer's read data and status on a valid/ready response channel.
- Drives any APB3 completer in the memories subsystem, including the SRAM bridge, and is the initiator used by local controllers and benches.
- One transfer is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, width of REQ_ADDR and PADDR.
- DATA_WIDTH, 32, APB data width; must be 8, 16, 32 or 64.
- TIMEOUT_CYCLES, 16, number of ACCESS cycles without PREADY before the requester aborts; 0 disables the timeout.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST_N  input  1  reset; synchronous and active-high (despite the name).
- REQ_VALID  input  1  command valid.
- REQ_READY  output  1  command accepted when high together with REQ_VALID.
- REQ_WRITE  input  1  1 = write, 0 = read.
- REQ_ADDR  input  ADDR_WIDTH  byte address.
- REQ_WDATA  input  DATA_WIDTH  write data.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  response consumed when high together with RSP_VALID.
- RSP_RDATA  output  DATA_WIDTH  read data; 0 for writes and errors.
- RSP_ERR  output  1  PSLVERR, timeout or misalignment.
- RSP_TIMEOUT  output  1  error cause is timeout.
- PSEL, PENABLE, PWRITE  output  1 each  APB3 control.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  input  1 each  APB completion and error.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: every output is 0, including REQ_READY, RSP_* and all P* signals. The FSM enters IDLE and the timeout counter is cleared.
- Reset mid-transfer: PSEL and PENABLE drop on the next edge. The transfer and any pending response are discarded with no RSP_VALID. A held request is re-evaluated from IDLE.

FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - REQ_READY=1, PSEL=0, PENABLE=0.
  - On REQ_VALID & REQ_READY, the command is registered into PADDR/PWRITE/PWDATA.
  - Aligned address (REQ_ADDR[log2(DATA_WIDTH/8)-1:0]==0): go to SETUP.
  - Misaligned address: go to RESP with RSP_ERR=1, RSP_TIMEOUT=0, RSP_RDATA=0. No APB cycle occurs.
- SETUP
  - PSEL=1, PENABLE=0, REQ_READY=0.
  - Always lasts exactly one cycle, then go to ACCESS.
- ACCESS
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE and PWDATA stay stable from SETUP to the end of ACCESS.
  - PREADY=1 completes the transfer at that edge:
    - read: RSP_RDATA<=PRDATA;
    - write: RSP_RDATA<=0;
    - RSP_ERR<=PSLVERR, RSP_TIMEOUT<=0;
    - go to RESP. PSEL and PENABLE are 0 from the next cycle.
  - PSLVERR is sampled only when PREADY=1. On a read error, RSP_RDATA is forced to 0.
  - Timeout counter: increments on each ACCESS cycle with PREADY=0.
  - When the count equals TIMEOUT_CYCLES (non-zero): abort, go to RESP with RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
  - If PREADY=1 arrives on the same cycle as the timeout, PREADY wins and the transfer completes normally.
- RESP
  - RSP_VALID=1 and response fields are held stable until RSP_READY.
  - On RSP_VALID & RSP_READY, go to IDLE. RSP_VALID=0 the next cycle.
  - REQ_READY stays 0 throughout RESP. There is no combinational path from RSP_READY to REQ_READY.

Latency and throughput:
- Handshake at edge t → SETUP in cycle t+1 → ACCESS in cycle t+2.
- With PREADY=1 in the first ACCESS cycle, RSP_VALID=1 in cycle t+3.
- Each wait state adds 1 cycle.
- Back-to-back throughput with RSP_READY tied high is one transfer per 4 cycles.

Registers:
- PADDR, PWRITE and PWDATA keep their last values while idle.
- All outputs are driven from registers or decoded only from FSM state. There are no combinational paths from inputs to outputs.

Test Plan:
1. Write 0xDEADBEEF to 0x8, completer PREADY=1 immediately → PSEL rises at t+1, PENABLE at t+2; PADDR=0x8 and PWDATA=0xDEADBEEF stable over 2 cycles; RSP_VALID at t+3 with RSP_ERR=0, RSP_RDATA=0.
2. Read 0x8 with 3 wait states and PRDATA=0xDEADBEEF → PENABLE high for 4 cycles; RSP_RDATA=0xDEADBEEF at t+6; RSP_ERR=0.
3. Read with PREADY=1 and PSLVERR=1 → RSP_ERR=1, RSP_TIMEOUT=0, RSP_RDATA=0. Also check PSLVERR=1 while PREADY=0 is ignored.
4. TIMEOUT_CYCLES=16, PREADY held 0 → abort after 16 ACCESS cycles: RSP_ERR=1, RSP_TIMEOUT=1, PSEL=0 the next cycle. Repeat with PREADY=1 on the 16th cycle → normal completion.
5. Request to 0x6 (DATA_WIDTH=32) → PSEL never asserted; RSP_VALID one cycle after the handshake with RSP_ERR=1. Also hold RSP_READY=0 for 5 cycles → response is stable and REQ_READY stays 0.
6. Assert RST_N for one cycle during ACCESS of a write → all outputs 0 the next cycle, no response emitted. A request held across reset is then accepted and completes normally.
